output_datapath_ctrl: RTL and testbench

//  Sequencer for output_datapath. Waits for done_matrix_mult from the systolic array.

---
 rtl/output_datapath_ctrl_if.sv | 23 ++
 rtl/output_datapath_ctrl.sv | 91 +++++++++
 tb/tb_output_datapath_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/output_datapath_ctrl_if.sv
// Handshake bundle between the output sequencer, the systolic array and the downstream consumer.
// The master side belongs to the sequencer; the slave side belongs to whatever drives its inputs.
interface output_datapath_ctrl_if;
   logic done_matrix_mult;
   logic dest_valid;
   logic sh_count_done;
   logic load_out;
   logic shift;
   logic src_ready;
   logic busy;
   logic out_done;
   logic seq_err;

   modport master (
      input  done_matrix_mult, dest_valid, sh_count_done,
      output load_out, shift, src_ready, busy, out_done, seq_err
   );

   modport slave (
      output done_matrix_mult, dest_valid, sh_count_done,
      input  load_out, shift, src_ready, busy, out_done, seq_err
   );
endinterface

// File: rtl/output_datapath_ctrl.sv
// Sequencer for output_datapath: captures a 512-bit systolic result and streams it
// downstream as NUM_CHUNKS 64-bit chunks using a src_ready/dest_valid handshake.
module output_datapath_ctrl #(
   parameter int NUM_CHUNKS = 8,
   parameter int CNT_W      = $clog2(NUM_CHUNKS)
) (
   input  logic                   clk,
   input  logic                   reset,
   output_datapath_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_LD,
      S_SEND,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] chunk_cnt;
   logic             pending;
   logic             done_q;
   logic             seq_err;
   logic             done_rise;
   logic             handshake;
   logic             last_chunk;

   // pending only reacts to a fresh rising request, so a level held from IDLE is not double-served
   assign done_rise  = bus.done_matrix_mult && !done_q;
   assign handshake  = (state == S_SEND) && bus.dest_valid;
   assign last_chunk = (chunk_cnt == LAST_CHUNK);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (bus.done_matrix_mult) state_nxt = S_LOAD;
         S_LOAD:    state_nxt = S_WAIT_LD;
         S_WAIT_LD: state_nxt = S_SEND;
         S_SEND:    if (handshake) state_nxt = last_chunk ? S_DONE : S_SHIFT;
         S_SHIFT:   state_nxt = S_SEND;
         S_DONE:    state_nxt = (pending || done_rise) ? S_LOAD : S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chunk_cnt <= '0;
         pending   <= 1'b0;
         done_q    <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         done_q <= bus.done_matrix_mult;
         if (state == S_LOAD)       chunk_cnt <= '0;
         else if (state == S_SHIFT) chunk_cnt <= chunk_cnt + 1'b1;
         // a request arriving in DONE is consumed by the DONE->LOAD transition itself
         if (state == S_DONE)
            pending <= 1'b0;
         else if (done_rise && (state inside {S_WAIT_LD, S_SEND, S_SHIFT}))
            pending <= 1'b1;
         if (handshake && (bus.sh_count_done != last_chunk))
            seq_err <= 1'b1;
      end
   end

   always_comb begin
      bus.load_out  = 1'b0;
      bus.shift     = 1'b0;
      bus.src_ready = 1'b0;
      bus.out_done  = 1'b0;
      bus.busy      = (state != S_IDLE);
      case (state)
         S_LOAD:  bus.load_out  = 1'b1;
         S_SEND:  bus.src_ready = 1'b1;
         S_SHIFT: bus.shift     = 1'b1;
         S_DONE:  bus.out_done  = 1'b1;
         default: ;
      endcase
   end

   assign bus.seq_err = seq_err;
endmodule

// File: tb/tb_output_datapath_ctrl.sv
// Directed bench for output_datapath_ctrl: latency, handshake, pending, async reset and seq_err.
module tb_output_datapath_ctrl;
   logic clk;
   logic reset;
   int   tests;
   int   failed;
   int   cyc, hs, sh, drop, first_sr, last_hs;

   output_datapath_ctrl_if bus ();

   output_datapath_ctrl #(.NUM_CHUNKS(8), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {bus.load_out, bus.shift, bus.src_ready, bus.busy, bus.out_done, bus.seq_err};
   endfunction

   // Drives one transfer from the LOAD cycle on; cyc counts cycles from LOAD to out_done.
   // sh_count_done follows the datapath model (high on the last chunk), inverted at bad_hs.
   task automatic stream(input bit rnd, input int p1, input int p2, input int bad_hs,
                         input int stop_hs, output int c, output int h, output int s,
                         output int d, output int fsr, output int lhs);
      logic dv;
      logic prev_wait;
      c = 0; h = 0; s = 0; d = 0; fsr = -1; lhs = -1;
      prev_wait = 1'b0;
      while (!bus.out_done && c < 200 && h != stop_hs) begin
         if (prev_wait && !bus.src_ready) d++;
         if (bus.shift && bus.src_ready)  d++;
         if (bus.shift) s++;
         if (bus.src_ready && fsr < 0) fsr = c;
         dv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.dest_valid       = dv;
         bus.done_matrix_mult = (c == p1) || (c == p2);
         bus.sh_count_done    = (h == 7) ^ (h == bad_hs);
         if (bus.src_ready && dv) begin
            h++;
            lhs = c;
         end
         prev_wait = bus.src_ready && !dv;
         tick();
         c++;
      end
      bus.done_matrix_mult = 1'b0;
      bus.sh_count_done    = 1'b0;
   endtask

   task automatic request();
      bus.done_matrix_mult = 1'b1;
      tick();
      bus.done_matrix_mult = 1'b0;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      reset  = 1'b0;
      bus.done_matrix_mult = 1'b0;
      bus.dest_valid       = 1'b0;
      bus.sh_count_done    = 1'b0;
      repeat (2) tick();
      chk("rst_outputs", 32'(outs()), 0);

      // T1: idle after reset release
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t1_idle", 32'(outs()), 0);
      end

      // T2: single pulse, dest_valid held high
      bus.done_matrix_mult = 1'b1;
      chk("t2_pre_load", 32'(bus.load_out), 0);
      tick();
      bus.done_matrix_mult = 1'b0;
      chk("t2_load_out", 32'(bus.load_out), 1);
      chk("t2_busy", 32'(bus.busy), 1);
      stream(1'b0, -1, -1, -1, -1, cyc, hs, sh, drop, first_sr, last_hs);
      chk("t2_first_src_ready", 32'(first_sr + 1), 3);
      chk("t2_out_done_lat", 32'(cyc + 1), 18);
      chk("t2_out_done", 32'(bus.out_done), 1);
      chk("t2_handshakes", 32'(hs), 8);
      chk("t2_shifts", 32'(sh), 7);
      chk("t2_rules", 32'(drop), 0);
      chk("t2_seq_err", 32'(bus.seq_err), 0);
      tick();
      chk("t2_idle_after", 32'(outs()), 0);

      // T3: random dest_valid
      request();
      stream(1'b1, -1, -1, -1, -1, cyc, hs, sh, drop, first_sr, last_hs);
      bus.dest_valid = 1'b0;
      chk("t3_handshakes", 32'(hs), 8);
      chk("t3_shifts", 32'(sh), 7);
      chk("t3_src_ready_steady", 32'(drop), 0);
      chk("t3_done_after_last", 32'(cyc), 32'(last_hs + 1));
      chk("t3_out_done", 32'(bus.out_done), 1);
      tick();
      chk("t3_idle_after", 32'(outs()), 0);

      // T4: second pulse at chunk 4, third pulse later in the same transfer
      request();
      stream(1'b0, 10, 13, -1, -1, cyc, hs, sh, drop, first_sr, last_hs);
      chk("t4_first_len", 32'(cyc), 17);
      chk("t4_first_hs", 32'(hs), 8);
      tick();
      chk("t4_second_load", 32'(bus.load_out), 1);
      stream(1'b0, -1, -1, -1, -1, cyc, hs, sh, drop, first_sr, last_hs);
      chk("t4_second_len", 32'(cyc), 17);
      chk("t4_second_hs", 32'(hs), 8);
      tick();
      chk("t4_served_once", 32'(outs()), 0);
      tick();
      chk("t4_still_idle", 32'(outs()), 0);

      // T5: async reset in the middle of a transfer
      request();
      stream(1'b0, -1, -1, -1, 3, cyc, hs, sh, drop, first_sr, last_hs);
      chk("t5_hs_before_reset", 32'(hs), 3);
      chk("t5_busy_before_reset", 32'(bus.busy), 1);
      bus.dest_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("t5_async_clear", 32'(outs()), 0);
      tick();
      reset = 1'b1;
      tick();
      chk("t5_idle_after_reset", 32'(outs()), 0);
      request();
      chk("t5_restart_load", 32'(bus.load_out), 1);
      stream(1'b0, -1, -1, -1, -1, cyc, hs, sh, drop, first_sr, last_hs);
      chk("t5_restart_hs", 32'(hs), 8);
      chk("t5_restart_len", 32'(cyc), 17);
      chk("t5_seq_err", 32'(bus.seq_err), 0);
      tick();

      // T6: sh_count_done wrong on the 2nd handshake
      request();
      stream(1'b0, -1, -1, 1, -1, cyc, hs, sh, drop, first_sr, last_hs);
      chk("t6_hs", 32'(hs), 8);
      chk("t6_shifts", 32'(sh), 7);
      chk("t6_out_done", 32'(bus.out_done), 1);
      chk("t6_seq_err_set", 32'(bus.seq_err), 1);
      bus.dest_valid = 1'b0;
      tick();
      chk("t6_seq_err_sticky", 32'(bus.seq_err), 1);
      chk("t6_idle", 32'(bus.busy), 0);
      repeat (3) tick();
      chk("t6_seq_err_still", 32'(bus.seq_err), 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_seq_err_reset", 32'(bus.seq_err), 0);
      tick();
      reset = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
